// File: rtl/avm_copy_pkg.sv
// avm_copy_pkg: shared FSM state type and address step for the Avalon-MM copy master
package avm_copy_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;
  localparam int ADDR_INC = 4;
endpackage

// File: rtl/avm_copy_master.sv
// avm_copy_master: copies LENGTH words from SRC_ADDR to DST_ADDR over an Avalon-MM master, one read then one write per word
//   clock/reset : CSI_CLOCK_CLK, CSI_CLOCK_RESET_N (async, active-low)
//   control     : START (rising edge starts a copy), SRC_ADDR, DST_ADDR, LENGTH (words) -> DONE pulse, BUSY level
//   avalon      : AVM_AVALONMASTER_ADDRESS/READ/WRITE/WRITEDATA out, READDATA/WAITREQUEST in
//   AVM_COPY_CHECKSUM_EN : adds CHECKSUM output, the wrapping sum of every word read in the last copy
module avm_copy_master
  import avm_copy_pkg::*;
#(
  parameter int AVM_AVALONMASTER_DATA_WIDTH    = 32,
  parameter int AVM_AVALONMASTER_ADDRESS_WIDTH = 32,
  parameter int LENGTH_WIDTH                   = 16
) (
  input  logic                                      CSI_CLOCK_CLK,
  input  logic                                      CSI_CLOCK_RESET_N,
  input  logic                                      START,
  input  logic [AVM_AVALONMASTER_ADDRESS_WIDTH-1:0] SRC_ADDR,
  input  logic [AVM_AVALONMASTER_ADDRESS_WIDTH-1:0] DST_ADDR,
  input  logic [LENGTH_WIDTH-1:0]                   LENGTH,
  output logic                                      DONE,
  output logic                                      BUSY,
`ifdef AVM_COPY_CHECKSUM_EN
  output logic [AVM_AVALONMASTER_DATA_WIDTH-1:0]    CHECKSUM,
`endif
  output logic [AVM_AVALONMASTER_ADDRESS_WIDTH-1:0] AVM_AVALONMASTER_ADDRESS,
  output logic                                      AVM_AVALONMASTER_READ,
  output logic                                      AVM_AVALONMASTER_WRITE,
  output logic [AVM_AVALONMASTER_DATA_WIDTH-1:0]    AVM_AVALONMASTER_WRITEDATA,
  input  logic [AVM_AVALONMASTER_DATA_WIDTH-1:0]    AVM_AVALONMASTER_READDATA,
  input  logic                                      AVM_AVALONMASTER_WAITREQUEST
);
  localparam int AW = AVM_AVALONMASTER_ADDRESS_WIDTH;
  localparam int DW = AVM_AVALONMASTER_DATA_WIDTH;
  localparam int LW = LENGTH_WIDTH;
  state_t          r_state, w_next;
  logic            r_start;
  logic [AW-1:0]   r_src, r_dst;
  logic [LW-1:0]   r_cnt;
  logic [DW-1:0]   r_data;
  logic            w_accept, w_rd_ack, w_wr_ack;
  assign w_accept = (r_state == IDLE) && START && !r_start;
  assign w_rd_ack = (r_state == READ) && !AVM_AVALONMASTER_WAITREQUEST;
  assign w_wr_ack = (r_state == WRITE) && !AVM_AVALONMASTER_WAITREQUEST;
  assign AVM_AVALONMASTER_WRITEDATA = r_data;
  always_ff @(posedge CSI_CLOCK_CLK or negedge CSI_CLOCK_RESET_N)
    if (!CSI_CLOCK_RESET_N) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    AVM_AVALONMASTER_READ = 1'b0;
    AVM_AVALONMASTER_WRITE = 1'b0;
    AVM_AVALONMASTER_ADDRESS = '0;
    DONE = 1'b0;
    BUSY = r_state != IDLE;
    case (r_state)
      IDLE: w_next = w_accept ? ((LENGTH == '0) ? FINISH : READ) : IDLE;
      READ: begin
        AVM_AVALONMASTER_READ = 1'b1;
        AVM_AVALONMASTER_ADDRESS = r_src;
        w_next = AVM_AVALONMASTER_WAITREQUEST ? READ : WRITE;
      end
      WRITE: begin
        AVM_AVALONMASTER_WRITE = 1'b1;
        AVM_AVALONMASTER_ADDRESS = r_dst;
        w_next = AVM_AVALONMASTER_WAITREQUEST ? WRITE : ((r_cnt == LW'(1)) ? FINISH : READ);
      end
      FINISH: begin
        DONE = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CSI_CLOCK_CLK or negedge CSI_CLOCK_RESET_N)
    if (!CSI_CLOCK_RESET_N) begin
      r_start <= 1'b0;
      r_src <= '0;
      r_dst <= '0;
      r_cnt <= '0;
      r_data <= '0;
    end else begin
      r_start <= START;
      if (w_accept) begin
        r_src <= SRC_ADDR;
        r_dst <= DST_ADDR;
        r_cnt <= LENGTH;
      end
      if (w_rd_ack) r_data <= AVM_AVALONMASTER_READDATA;
      if (w_wr_ack) begin
        r_cnt <= r_cnt - LW'(1);
        r_src <= r_src + AW'(ADDR_INC);
        r_dst <= r_dst + AW'(ADDR_INC);
      end
    end
`ifdef AVM_COPY_CHECKSUM_EN
  logic [DW-1:0] r_sum;
  assign CHECKSUM = r_sum;
  always_ff @(posedge CSI_CLOCK_CLK or negedge CSI_CLOCK_RESET_N)
    if (!CSI_CLOCK_RESET_N) r_sum <= '0;
    else if (w_accept) r_sum <= '0;
    else if (w_rd_ack) r_sum <= r_sum + AVM_AVALONMASTER_READDATA;
`endif
endmodule
